// File: rtl/instr_fetch_seq_pkg.sv
// Shared wasm front-end defines: fetch window geometry and sequencer states.
package instr_fetch_seq_pkg;

    localparam int ADDR_WIDTH = 10;
    localparam int READ_WIN   = 8;
    localparam int SHIFT_W    = $clog2(READ_WIN);
    localparam int CNT_W      = 32;
    localparam int WIN_W      = READ_WIN * 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/instr_fetch_seq_if.sv
// Memory-side and decoder-side bundle of the instruction fetch sequencer.
interface instr_fetch_seq_if;
    import instr_fetch_seq_pkg::*;

    logic                  mem_re;
    logic [WIN_W-1:0]      mem_rd_data;
    logic                  mem_rd_data_vld;
    logic                  mem_shift_vld;
    logic [SHIFT_W-1:0]    mem_shift_m1;
    logic                  mem_jump_en;
    logic [ADDR_WIDTH-1:0] mem_jump_addr;
    logic                  mem_instr_finish;
    logic [ADDR_WIDTH-1:0] mem_rd_ptr;

    logic                  win_vld;
    logic [WIN_W-1:0]      win_data;
    logic [ADDR_WIDTH-1:0] win_pc;
    logic                  dec_take;
    logic [SHIFT_W-1:0]    dec_len_m1;
    logic                  dec_jump;
    logic [ADDR_WIDTH-1:0] dec_jump_addr;

    modport master (
        output mem_re, mem_shift_vld, mem_shift_m1, mem_jump_en, mem_jump_addr,
        output win_vld, win_data, win_pc,
        input  mem_rd_data, mem_rd_data_vld, mem_instr_finish, mem_rd_ptr,
        input  dec_take, dec_len_m1, dec_jump, dec_jump_addr
    );

    modport slave (
        input  mem_re, mem_shift_vld, mem_shift_m1, mem_jump_en, mem_jump_addr,
        input  win_vld, win_data, win_pc,
        output mem_rd_data, mem_rd_data_vld, mem_instr_finish, mem_rd_ptr,
        output dec_take, dec_len_m1, dec_jump, dec_jump_addr
    );

endinterface

// File: rtl/instr_fetch_seq.sv
// Fetch sequencer: reads windows from instruction memory, presents them to
// the decoder and turns each consume into a memory shift or jump update.
module instr_fetch_seq
    import instr_fetch_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             hlt,
    instr_fetch_seq_if.master bus,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t                state, state_nxt;
    logic                  pend_jump, pend_nxt;
    logic [ADDR_WIDTH-1:0] target, target_nxt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [WIN_W-1:0]      win_data_q;
    logic [ADDR_WIDTH-1:0] win_pc_q;
    logic                  cap;
    logic                  xfer;

    assign xfer = (state == PRESENT) & bus.dec_take & ~hlt;

    always_comb begin
        state_nxt         = state;
        pend_nxt          = pend_jump;
        target_nxt        = target;
        cnt_nxt           = instr_cnt;
        cap               = 1'b0;
        bus.mem_re        = 1'b0;
        bus.mem_shift_vld = 1'b0;
        bus.mem_shift_m1  = '0;
        bus.mem_jump_en   = 1'b0;
        bus.mem_jump_addr = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FETCH;
                    cnt_nxt   = '0;
                end
            end
            FETCH: begin
                bus.mem_re        = 1'b1;
                bus.mem_jump_en   = pend_jump;
                bus.mem_jump_addr = target;
                // a pending jump means the read pointer is about to move,
                // so finish only counts on a committed pointer
                if (bus.mem_instr_finish && !pend_jump) begin
                    state_nxt = DONE;
                end else if (bus.mem_rd_data_vld) begin
                    cap       = 1'b1;
                    state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                bus.mem_jump_en   = pend_jump;
                bus.mem_jump_addr = target;
                if (xfer) begin
                    state_nxt = FETCH;
                    cnt_nxt   = sat_inc(instr_cnt);
                    if (bus.dec_jump) begin
                        pend_nxt   = 1'b1;
                        target_nxt = bus.dec_jump_addr;
                    end else begin
                        bus.mem_shift_vld = 1'b1;
                        bus.mem_shift_m1  = bus.dec_len_m1;
                        pend_nxt          = 1'b0;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt = FETCH;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // abort overrides everything, including a coincident transfer
        if (abort) begin
            state_nxt         = IDLE;
            pend_nxt          = 1'b0;
            target_nxt        = target;
            cnt_nxt           = instr_cnt;
            cap               = 1'b0;
            bus.mem_shift_vld = 1'b0;
            bus.mem_shift_m1  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pend_jump  <= 1'b0;
            target     <= '0;
            instr_cnt  <= '0;
            win_data_q <= '0;
            win_pc_q   <= '0;
        end else begin
            state     <= state_nxt;
            pend_jump <= pend_nxt;
            target    <= target_nxt;
            instr_cnt <= cnt_nxt;
            if (cap) begin
                win_data_q <= bus.mem_rd_data;
                win_pc_q   <= bus.mem_rd_ptr;
            end
        end
    end

    assign bus.win_vld  = (state == PRESENT);
    assign bus.win_data = win_data_q;
    assign bus.win_pc   = win_pc_q;
    assign busy         = (state == FETCH) || (state == PRESENT);
    assign done         = (state == DONE);

endmodule
